// File: rtl/tail_light_pkg.sv
// tail_light_pkg
//   Shared types and helpers for the tail-light sequencer.
//   tl_state_t : sequencer states (idle, left/right sweep, hazard on/off).
//   tl_thermo  : count -> thermometer code, returned at TL_MAX_LAMPS width;
//                callers cast the result down to their own bank width.
//   Bank widths up to TL_MAX_LAMPS lamps are supported.
package tail_light_pkg;

    localparam int TL_MAX_LAMPS = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEFT    = 3'd1,
        RIGHT   = 3'd2,
        HAZ_ON  = 3'd3,
        HAZ_OFF = 3'd4
    } tl_state_t;

    // Lamp i is lit when count > i, so count=0 is all off and count>=width
    // is all on.
    function automatic logic [TL_MAX_LAMPS-1:0] tl_thermo(input int unsigned count);
        logic [TL_MAX_LAMPS-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < TL_MAX_LAMPS; i++) begin
            t[i] = (count > i);
        end
        return t;
    endfunction

endpackage

// File: rtl/tl_prescaler.sv
// tl_prescaler
//   Divides the clock into a one-cycle-wide step enable.
//   Parameters: DIV - clock cycles per tick (>=1); DIV=1 ticks every clock.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous active-high reset, clears the counter
//     tick  - high for one cycle out of every DIV
//   After reset the first tick is seen on rising edge number DIV.
module tl_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int                 CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // With DIV=1 the counter sits at 0, which is also CNT_LAST, so tick is
    // permanently high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tail_light_seq.sv
// tail_light_seq
//   Turn-signal sequencer: sweeps a thermometer pattern outward on the
//   requested bank, flashes both banks in hazard mode, and advances only on
//   prescaler ticks.
//   Parameters: LAMPS - lamps per bank (1..32), DIV - clocks per step (>=1).
//   Ports:
//     clk, reset        - clock and asynchronous active-high reset
//     left, right       - turn requests (level), sampled on tick edges
//     hazard            - hazard request (level), sampled on tick edges
//     brake             - brake pedal, only with TAIL_LIGHT_BRAKE_EN
//     l_lamps, r_lamps  - lamp banks, bit 0 innermost
//   Build option: define TAIL_LIGHT_BRAKE_EN to add the brake input.
//   Outputs are decoded from registers only.
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int LAMPS = 3,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
`ifdef TAIL_LIGHT_BRAKE_EN
    input  logic             brake,
`endif
    output logic [LAMPS-1:0] l_lamps,
    output logic [LAMPS-1:0] r_lamps
);

    localparam int                STEP_W    = $clog2(LAMPS + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAMPS);

    tl_state_t        state, state_nxt;
    logic [STEP_W-1:0] step, step_nxt;
    logic             tick;
    logic [LAMPS-1:0] sweep;

    tl_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // State register: the next-state logic is always evaluated, but only
    // committed on tick edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            step  <= '0;
        end else if (tick) begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // Next-state logic. A sweep always runs to completion (including the
    // all-off step back in IDLE) unless hazard preempts it.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            IDLE: begin
                step_nxt = '0;
                if (hazard) begin
                    state_nxt = HAZ_ON;
                end else if (left && !right) begin
                    state_nxt = LEFT;
                    step_nxt  = STEP_W'(1);
                end else if (right && !left) begin
                    state_nxt = RIGHT;
                    step_nxt  = STEP_W'(1);
                end
            end
            LEFT, RIGHT: begin
                if (hazard) begin
                    state_nxt = HAZ_ON;
                    step_nxt  = '0;
                end else if (step == STEP_LAST) begin
                    state_nxt = IDLE;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step + STEP_W'(1);
                end
            end
            HAZ_ON: begin
                state_nxt = HAZ_OFF;
                step_nxt  = '0;
            end
            HAZ_OFF: begin
                state_nxt = IDLE;
                step_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
                step_nxt  = '0;
            end
        endcase
    end

`ifdef TAIL_LIGHT_BRAKE_EN
    logic brake_q;

    // Brake is resynchronised every clock, independent of the step tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brake_q <= 1'b0;
        end else begin
            brake_q <= brake;
        end
    end
`endif

    assign sweep = LAMPS'(tl_thermo(32'(step)));

    // Lamp decode from state/step. With brake, any bank that is not
    // sweeping is lit solid, except during the hazard flash.
    always_comb begin
        l_lamps = '0;
        r_lamps = '0;
        case (state)
            LEFT:    l_lamps = sweep;
            RIGHT:   r_lamps = sweep;
            HAZ_ON: begin
                l_lamps = '1;
                r_lamps = '1;
            end
            default: ;
        endcase
`ifdef TAIL_LIGHT_BRAKE_EN
        if (brake_q) begin
            case (state)
                IDLE: begin
                    l_lamps = '1;
                    r_lamps = '1;
                end
                LEFT:    r_lamps = '1;
                RIGHT:   l_lamps = '1;
                default: ;
            endcase
        end
`endif
    end

endmodule

// File: tb/tb_tail_light_seq.sv
// tb_tail_light_seq
//   Directed checks of tail_light_seq with hand-computed lamp patterns:
//   instance a (LAMPS=3, DIV=1) runs a table of per-cycle vectors,
//   instance b (LAMPS=3, DIV=4) covers the slow pulse and mid-sweep reset,
//   instance c (LAMPS=5, DIV=2) covers hazard preemption mid-sweep,
//   instance d (LAMPS=3, DIV=1) covers brake when TAIL_LIGHT_BRAKE_EN is set.
module tb_tail_light_seq;

    typedef struct {
        logic       left;
        logic       right;
        logic       hazard;
        logic [2:0] exp_l;
        logic [2:0] exp_r;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic       a_reset = 1'b1, a_left = 1'b0, a_right = 1'b0, a_hazard = 1'b0;
    logic [2:0] a_l, a_r;
    logic       b_reset = 1'b1, b_left = 1'b0, b_right = 1'b0, b_hazard = 1'b0;
    logic [2:0] b_l, b_r;
    logic       c_reset = 1'b1, c_left = 1'b0, c_right = 1'b0, c_hazard = 1'b0;
    logic [4:0] c_l, c_r;

    tail_light_seq #(.LAMPS(3), .DIV(1)) dut_a (
        .clk(clk), .reset(a_reset), .left(a_left), .right(a_right), .hazard(a_hazard),
`ifdef TAIL_LIGHT_BRAKE_EN
        .brake(1'b0),
`endif
        .l_lamps(a_l), .r_lamps(a_r)
    );

    tail_light_seq #(.LAMPS(3), .DIV(4)) dut_b (
        .clk(clk), .reset(b_reset), .left(b_left), .right(b_right), .hazard(b_hazard),
`ifdef TAIL_LIGHT_BRAKE_EN
        .brake(1'b0),
`endif
        .l_lamps(b_l), .r_lamps(b_r)
    );

    tail_light_seq #(.LAMPS(5), .DIV(2)) dut_c (
        .clk(clk), .reset(c_reset), .left(c_left), .right(c_right), .hazard(c_hazard),
`ifdef TAIL_LIGHT_BRAKE_EN
        .brake(1'b0),
`endif
        .l_lamps(c_l), .r_lamps(c_r)
    );

`ifdef TAIL_LIGHT_BRAKE_EN
    logic       d_reset = 1'b1, d_left = 1'b0, d_right = 1'b0, d_hazard = 1'b0, d_brake = 1'b0;
    logic [2:0] d_l, d_r;

    tail_light_seq #(.LAMPS(3), .DIV(1)) dut_d (
        .clk(clk), .reset(d_reset), .left(d_left), .right(d_right), .hazard(d_hazard),
        .brake(d_brake),
        .l_lamps(d_l), .r_lamps(d_r)
    );
`endif

    vec_t vecs[$];

    task automatic add_vec(input logic l, input logic r, input logic h,
                           input logic [2:0] el, input logic [2:0] er);
        vec_t v;
        v.left = l; v.right = r; v.hazard = h; v.exp_l = el; v.exp_r = er;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        a_left   = v.left;
        a_right  = v.right;
        a_hazard = v.hazard;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle 2 time units past it.
    task automatic next_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Table for instance a: left sweep, both requests, hazard flash,
        // right sweep, mid-sweep request change, hazard preemption.
        for (int i = 0; i < 2; i++) begin
            add_vec(1, 0, 0, 3'b001, 3'b000);
            add_vec(1, 0, 0, 3'b011, 3'b000);
            add_vec(1, 0, 0, 3'b111, 3'b000);
            add_vec(1, 0, 0, 3'b000, 3'b000);
        end
        for (int i = 0; i < 3; i++) add_vec(1, 1, 0, 3'b000, 3'b000);
        for (int i = 0; i < 2; i++) begin
            add_vec(1, 1, 1, 3'b111, 3'b111);
            add_vec(1, 1, 1, 3'b000, 3'b000);
            add_vec(1, 1, 1, 3'b000, 3'b000);
        end
        add_vec(0, 1, 0, 3'b000, 3'b001);
        add_vec(0, 1, 0, 3'b000, 3'b011);
        add_vec(0, 1, 0, 3'b000, 3'b111);
        add_vec(0, 1, 0, 3'b000, 3'b000);
        add_vec(0, 0, 0, 3'b000, 3'b000);
        add_vec(1, 0, 0, 3'b001, 3'b000);
        add_vec(0, 1, 0, 3'b011, 3'b000);
        add_vec(0, 1, 0, 3'b111, 3'b000);
        add_vec(0, 1, 0, 3'b000, 3'b000);
        add_vec(0, 1, 0, 3'b000, 3'b001);
        add_vec(0, 0, 0, 3'b000, 3'b011);
        add_vec(0, 0, 0, 3'b000, 3'b111);
        add_vec(0, 0, 0, 3'b000, 3'b000);
        add_vec(0, 0, 0, 3'b000, 3'b000);
        add_vec(1, 0, 0, 3'b001, 3'b000);
        add_vec(0, 0, 1, 3'b111, 3'b111);
        add_vec(0, 0, 0, 3'b000, 3'b000);
        add_vec(0, 0, 0, 3'b000, 3'b000);
        add_vec(0, 0, 0, 3'b000, 3'b000);

        // ---------------- instance a: reset state then table ----------------
        #1;
        checkOutput("a reset l_lamps", {5'b0, a_l}, 8'b0);
        checkOutput("a reset r_lamps", {5'b0, a_r}, 8'b0);
        next_edge();
        checkOutput("a held reset l_lamps", {5'b0, a_l}, 8'b0);
        a_left  = 1'b1;
        a_reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            next_edge();
            checkOutput($sformatf("a row %0d l_lamps", i), {5'b0, a_l}, {5'b0, vecs[i].exp_l});
            checkOutput($sformatf("a row %0d r_lamps", i), {5'b0, a_r}, {5'b0, vecs[i].exp_r});
        end
        a_left = 1'b0; a_right = 1'b0; a_hazard = 1'b0;

        // ---------------- instance b: right pulsed around first tick --------
        b_reset = 1'b1;
        next_edge();
        b_reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            logic [2:0] exp_r;
            if (k == 2) b_right = 1'b1;
            next_edge();
            if (k == 5) b_right = 1'b0;
            if (k < 4)       exp_r = 3'b000;
            else if (k < 8)  exp_r = 3'b001;
            else if (k < 12) exp_r = 3'b011;
            else if (k < 16) exp_r = 3'b111;
            else             exp_r = 3'b000;
            checkOutput($sformatf("b pulse edge %0d r_lamps", k), {5'b0, b_r}, {5'b0, exp_r});
            checkOutput($sformatf("b pulse edge %0d l_lamps", k), {5'b0, b_l}, 8'b0);
        end

        // ---------------- instance b: reset mid-sweep -----------------------
        b_reset = 1'b1;
        next_edge();
        b_reset = 1'b0;
        b_right = 1'b1;
        for (int k = 1; k <= 9; k++) next_edge();
        checkOutput("b mid-sweep before reset", {5'b0, b_r}, 8'b0000_0011);
        #2;
        b_reset = 1'b1;
        #1;
        checkOutput("b async reset r_lamps", {5'b0, b_r}, 8'b0);
        next_edge();
        checkOutput("b reset held r_lamps", {5'b0, b_r}, 8'b0);
        b_reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            next_edge();
            checkOutput($sformatf("b restart edge %0d r_lamps", k), {5'b0, b_r}, 8'b0);
        end
        next_edge();
        checkOutput("b restart edge 4 r_lamps", {5'b0, b_r}, 8'b0000_0001);
        b_right = 1'b0;

        // ---------------- instance c: hazard preempts at step 2 -------------
        c_reset = 1'b1;
        next_edge();
        c_reset = 1'b0;
        c_left  = 1'b1;
        begin
            logic [4:0] exp_l_c[12];
            logic [4:0] exp_r_c[12];
            exp_l_c = '{5'b00000, 5'b00001, 5'b00001, 5'b00011, 5'b00011, 5'b11111,
                        5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b11111};
            exp_r_c = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b11111,
                        5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b11111};
            for (int k = 1; k <= 12; k++) begin
                next_edge();
                checkOutput($sformatf("c edge %0d l_lamps", k), {3'b0, c_l}, {3'b0, exp_l_c[k-1]});
                checkOutput($sformatf("c edge %0d r_lamps", k), {3'b0, c_r}, {3'b0, exp_r_c[k-1]});
                if (k == 4) c_hazard = 1'b1;
            end
        end
        c_left = 1'b0; c_hazard = 1'b0;

`ifdef TAIL_LIGHT_BRAKE_EN
        // ---------------- instance d: brake with left sweep and hazard ------
        #1;
        checkOutput("d reset l_lamps", {5'b0, d_l}, 8'b0);
        d_brake = 1'b1;
        next_edge();
        checkOutput("d reset with brake r_lamps", {5'b0, d_r}, 8'b0);
        d_brake = 1'b0;
        d_reset = 1'b0;
        d_left  = 1'b1;
        begin
            logic [2:0] exp_l_d[10];
            logic [2:0] exp_r_d[10];
            exp_l_d = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b001, 3'b011,
                        3'b111, 3'b000, 3'b111, 3'b000};
            exp_r_d = '{3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                        3'b111, 3'b000, 3'b111, 3'b000};
            for (int k = 1; k <= 10; k++) begin
                next_edge();
                checkOutput($sformatf("d edge %0d l_lamps", k), {5'b0, d_l}, {5'b0, exp_l_d[k-1]});
                checkOutput($sformatf("d edge %0d r_lamps", k), {5'b0, d_r}, {5'b0, exp_r_d[k-1]});
                if (k == 1) d_brake = 1'b1;
                if (k == 6) d_hazard = 1'b1;
                if (k == 9) begin
                    d_hazard = 1'b0;
                    d_left   = 1'b0;
                    d_brake  = 1'b0;
                end
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tail_light_seq.md
# tail_light_seq

Parametrised sequential turn-signal controller for the finite-state-machine lab set, driving two banks of `LAMPS` lamps each. It sweeps a thermometer pattern outward on the requested side, adds a hazard mode that flashes both banks, and paces every step with an integrated prescaler tick. It sits between the driver-switch inputs and the lamp driver pins.

## Interface
- `LAMPS`, default 3: lamps per side, ≥1.
- `DIV`, default 1: clock cycles per sequence step, ≥1. `DIV=1` steps every clock.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `left` input, 1 bit: left turn request, level.
- `right` input, 1 bit: right turn request, level.
- `hazard` input, 1 bit: hazard request, level.
- `brake` input, 1 bit: brake pedal, level. Present only with `TAIL_LIGHT_BRAKE_EN`.
- `l_lamps` output, `LAMPS` bits: left bank; bit 0 is the innermost lamp.
- `r_lamps` output, `LAMPS` bits: right bank; bit 0 is the innermost lamp.

## Operation
- States: `IDLE`, `LEFT`, `RIGHT`, `HAZ_ON`, `HAZ_OFF`. A step counter `step` runs 0..`LAMPS` and is used in `LEFT`/`RIGHT`.
- Transitions happen only on clock edges where `tick`=1.
- From `IDLE`, priority is `hazard` > (`left` & ~`right`) > (`right` & ~`left`):
  - `hazard`: go to `HAZ_ON`.
  - `left` only: go to `LEFT`, step=1.
  - `right` only: go to `RIGHT`, step=1.
  - `left`&`right` without `hazard`, or no input: stay in `IDLE`.
- `LEFT`/`RIGHT`:
  - step<`LAMPS`: step+1.
  - step=`LAMPS`: go to `IDLE`, unconditionally.
  - `left`/`right` changes mid-sweep are ignored.
- `hazard` at any tick while in `LEFT`/`RIGHT` preempts: go to `HAZ_ON`, step=0.
- `HAZ_ON` goes to `HAZ_OFF`. `HAZ_OFF` goes to `IDLE`, which re-evaluates on its next tick. The hazard flash period is therefore 3 ticks: on, off, idle-off.
- Lamp decode:
  - `LEFT`: `l_lamps[i]`=1 when step>i.
  - `RIGHT`: same rule on `r_lamps`.
  - `HAZ_ON`: both banks all ones.
  - All other states: zeros.
- Outputs are decoded from state registers only. There is no combinational path from inputs to outputs.
- Prescaler:
  - Counter `cnt` has width max(1,$clog2(`DIV`)).
  - `tick`=(`cnt`==`DIV`-1). On tick, `cnt` goes to 0; otherwise it increments.
  - `DIV`=1 gives `tick`≡1.

## Timing
- Reset asserted, asynchronously:
  - state=`IDLE`, step=0, `cnt`=0, brake register=0.
  - `l_lamps`=`r_lamps`=0, immediately and for as long as `reset` is held.
- Reset mid-sweep aborts the sweep. There is no resumption.
- First tick after reset release: rising edge number `DIV`.
- Latency from an `IDLE` tick edge to the first lamp lit: that same edge. Request inputs must be stable at that edge.
- Full sweep lasts `LAMPS`+1 ticks, including one all-off tick. A held request repeats the sweep back to back.
- Inputs are sampled only at tick edges. Pulses shorter than `DIV` cycles may be missed; this is by design.

## Configuration
- `TAIL_LIGHT_BRAKE_EN` defined:
  - Adds the `brake` port, registered every clock (1-cycle latency, independent of tick).
  - While the registered brake=1, a bank not currently sweeping is forced to all ones.
  - The sweeping bank keeps its sweep pattern.
  - In `HAZ_ON`/`HAZ_OFF`, brake is ignored.
  - In `IDLE`, both banks are all ones.
- `TAIL_LIGHT_BRAKE_EN` undefined: no `brake` port. Behaviour is exactly as described above.

## Structure
- `tail_light_pkg`: state enum `tl_state_t`, and a `tl_thermo` function (count → `LAMPS`-bit thermometer).
- Sub-module `tl_prescaler` #(`DIV`): inputs `clk`, `reset`; output `tick`.
- Top level: FSM, step counter, lamp decode and optional brake register.

## Test plan
- `LAMPS`=3, `DIV`=1, `left` held from reset release → `l_lamps` 001,011,111,000 repeating every 4 cycles; `r_lamps`=000 throughout.
- `LAMPS`=3, `DIV`=4, `right` pulsed for 4 cycles around the first tick → `r_lamps` 001 for 4 cycles, then 011 for 4, then 111 for 4, then 000; no second sweep.
- `LAMPS`=3, `DIV`=1, `left`=`right`=1 → both banks 000 indefinitely. Then `hazard`=1 → both banks 111,000,000 repeating.
- `LAMPS`=5, `DIV`=2, `left` sweep with `hazard` asserted at step 2 → next tick both banks 11111, then 00000, then 00000.
- Reset asserted mid-sweep between clock edges → lamps 0 within the same cycle; after release, sweep restarts at step 1 on tick `DIV`.
- With `TAIL_LIGHT_BRAKE_EN`, `LAMPS`=3, `DIV`=1, `brake`=1 and `left` held → `r_lamps`=111 from the 2nd edge; `l_lamps` 001,011,111,111 (the all-off step shows brake), repeating.
